// File: rtl/game_round_ctrl.sv
// game_round_ctrl: reaction-game round controller. Issues a pseudo-random
// instruction, waits for a key press-and-release inside a response window,
// handshakes with an external judge, shows timed feedback and tracks lives
// and a saturating score until game over.
// Optional feature macro: ROUND_SPEEDUP_EN -- shrinks the response window
// every SPEEDUP_EVERY-th correct answer, floored at MIN_TIMEOUT.
module game_round_ctrl #(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned LIFE_W       = 2,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned TMR_W        = 16,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned FEEDBACK_CYC = 200,
  parameter int unsigned INSTR_W      = 3,
  parameter int unsigned NUM_INSTR    = 6,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
`ifdef ROUND_SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_EVERY = 4,
  parameter int unsigned SPEEDUP_STEP  = 50,
  parameter int unsigned MIN_TIMEOUT   = 100
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               key_pressed,
  input  logic               judge_valid,
  input  logic               judge_correct,
  output logic               judge_req,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [LIFE_W-1:0]  lives,
  output logic [SCORE_W-1:0] score,
  output logic               correct_flag,
  output logic               wrong_flag,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_NEW_INSTR    = 3'd1;
  localparam logic [2:0] S_WAIT_KEY     = 3'd2;
  localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
  localparam logic [2:0] S_JUDGE        = 3'd4;
  localparam logic [2:0] S_FB_CORRECT   = 3'd5;
  localparam logic [2:0] S_FB_WRONG     = 3'd6;
  localparam logic [2:0] S_GAME_OVER    = 3'd7;

  localparam logic [TMR_W-1:0] FB_LAST = TMR_W'(FEEDBACK_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] win_last;
  logic [7:0]       lfsr_q;
  logic             key_q;
  logic             key_rise;
  logic             fb_done;
  logic             load;
  logic             correct_entry;
  logic             wrong_entry;

  assign key_rise      = key_pressed & ~key_q;
  assign fb_done       = (timer_q == FB_LAST);
  assign load          = start && ((state_q == S_IDLE) || (state_q == S_GAME_OVER));
  assign correct_entry = (state_d == S_FB_CORRECT) && (state_q != S_FB_CORRECT);
  assign wrong_entry   = (state_d == S_FB_WRONG) && (state_q != S_FB_WRONG);

`ifdef ROUND_SPEEDUP_EN
  localparam int unsigned      SPD_W    = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;
  localparam logic [SPD_W-1:0] SPD_LAST = SPD_W'(SPEEDUP_EVERY - 1);
  localparam logic [TMR_W-1:0] WIN_INIT = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] WIN_STEP = TMR_W'(SPEEDUP_STEP);
  localparam logic [TMR_W-1:0] WIN_MIN  = TMR_W'(MIN_TIMEOUT);

  logic [SPD_W-1:0] spd_cnt_q;
  logic [TMR_W-1:0] window_q;

  // Live response window: reloads on start, shrinks every N-th correct answer
  always_ff @(posedge clk) begin
    if (rst || load) begin
      window_q  <= WIN_INIT;
      spd_cnt_q <= '0;
    end else if (correct_entry) begin
      if (spd_cnt_q == SPD_LAST) begin
        spd_cnt_q <= '0;
        window_q  <= (window_q >= WIN_MIN + WIN_STEP) ? window_q - WIN_STEP : WIN_MIN;
      end else begin
        spd_cnt_q <= spd_cnt_q + SPD_W'(1);
      end
    end
  end

  assign win_last = window_q - TMR_W'(1);
`else
  assign win_last = TMR_W'(TIMEOUT_CYC - 1);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a key edge on the timeout cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: if (start) state_d = S_NEW_INSTR;
      S_NEW_INSTR:         state_d = S_WAIT_KEY;
      S_WAIT_KEY: begin
        if (key_rise)                state_d = S_WAIT_RELEASE;
        else if (timer_q == win_last) state_d = S_FB_WRONG;
      end
      S_WAIT_RELEASE:      if (!key_pressed) state_d = S_JUDGE;
      S_JUDGE:             if (judge_valid) state_d = judge_correct ? S_FB_CORRECT : S_FB_WRONG;
      S_FB_CORRECT:        if (fb_done) state_d = S_NEW_INSTR;
      S_FB_WRONG:          if (fb_done) state_d = (lives == '0) ? S_GAME_OVER : S_NEW_INSTR;
      default:             state_d = S_IDLE;
    endcase
  end

  // Free-running LFSR (x^8+x^6+x^5+x^4+1) and key history
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      key_q  <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      key_q  <= key_pressed;
    end
  end

  // Shared timer: response window in WAIT_KEY, display time in feedback
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if ((state_q == S_NEW_INSTR) || correct_entry || wrong_entry) begin
      timer_q <= '0;
    end else if (((state_q == S_WAIT_KEY) && (state_d == S_WAIT_KEY)) ||
                 (state_q == S_FB_CORRECT) || (state_q == S_FB_WRONG)) begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Instruction, lives and score bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
      lives       <= '0;
      score       <= '0;
    end else begin
      if (state_q == S_NEW_INSTR) instruction <= INSTR_W'(lfsr_q % 8'(NUM_INSTR));
      if (load) begin
        lives <= LIFE_W'(START_LIVES);
        score <= '0;
      end else begin
        if (wrong_entry && (lives != '0)) lives <= lives - LIFE_W'(1);
        if (correct_entry && (score != '1)) score <= score + SCORE_W'(1);
      end
    end
  end

  // Registered status outputs decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      judge_req    <= 1'b0;
      instr_valid  <= 1'b0;
      correct_flag <= 1'b0;
      wrong_flag   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      judge_req    <= (state_d == S_JUDGE);
      instr_valid  <= (state_d == S_WAIT_KEY) || (state_d == S_WAIT_RELEASE) ||
                      (state_d == S_JUDGE);
      correct_flag <= (state_d == S_FB_CORRECT);
      wrong_flag   <= (state_d == S_FB_WRONG);
      game_over    <= (state_d == S_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: table-driven per-cycle vectors for game_round_ctrl,
// plus hand-written timing sequences (window length, feedback length and,
// with ROUND_SPEEDUP_EN, the shrinking window).
module tb_game_round_ctrl;

  localparam int X_IDL = 0;
  localparam int X_NEW = 1;
  localparam int X_WK  = 2;
  localparam int X_WR  = 3;
  localparam int X_JG  = 4;
  localparam int X_FBC = 5;
  localparam int X_FBW = 6;
  localparam int X_GO  = 7;

  typedef struct {
    int         st;
    logic       rst, start, key, jv, jc;
    logic [1:0] lv, sc;
  } vec_t;

  logic       clk, rst, start, key_pressed, judge_valid, judge_correct;
  logic       judge_req, instr_valid, correct_flag, wrong_flag, game_over;
  logic [2:0] instruction;
  logic [1:0] lives, score;

  vec_t       vt[$];
  logic [1:0] f_lv, f_sc;
  logic [7:0] m_lfsr;
  logic [2:0] exp_instr, pend_val;
  logic       pend;
  int         n_vec, n_bad, n;

  game_round_ctrl #(
    .START_LIVES(3), .LIFE_W(2), .SCORE_W(2), .TMR_W(16), .TIMEOUT_CYC(8),
    .FEEDBACK_CYC(4), .INSTR_W(3), .NUM_INSTR(6), .LFSR_SEED(8'hA5)
`ifdef ROUND_SPEEDUP_EN
    , .SPEEDUP_EVERY(2), .SPEEDUP_STEP(2), .MIN_TIMEOUT(5)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_pressed(key_pressed),
    .judge_valid(judge_valid), .judge_correct(judge_correct),
    .judge_req(judge_req), .instruction(instruction), .instr_valid(instr_valid),
    .lives(lives), .score(score), .correct_flag(correct_flag),
    .wrong_flag(wrong_flag), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR from the polynomial, used to predict instruction codes
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic k, input logic v, input logic c);
    start = s; key_pressed = k; judge_valid = v; judge_correct = c;
    step();
  endtask

  task automatic check(input string name, input int idx, input logic [11:0] act,
                       input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int st, input logic r, input logic s, input logic k,
                     input logic v, input logic c);
    vec_t e;
    e.st = st; e.rst = r; e.start = s; e.key = k; e.jv = v; e.jc = c;
    e.lv = f_lv; e.sc = f_sc;
    vt.push_back(e);
  endtask

  // From WAIT_KEY t0: no accepted press, timeout, feedback, then next state
  task automatic to_round(input logic k);
    for (int i = 0; i < 7; i++) add(X_WK, 1'b0, i == 2, k, i == 2, i == 2);
    f_lv = f_lv - 2'd1;
    add(X_FBW, 1'b0, 1'b0, k, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(X_FBW, 1'b0, 1'b0, k, 1'b0, 1'b0);
    add((f_lv == 2'd0) ? X_GO : X_NEW, 1'b0, 1'b0, k, 1'b0, 1'b0);
  endtask

  // From WAIT_KEY t0: press, release, judge after w idle cycles, correct
  task automatic correct_round(input int w);
    add(X_WR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(X_JG, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < w; i++) add(X_JG, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (f_sc != 2'd3) f_sc = f_sc + 2'd1;
    add(X_FBC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(X_FBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_NEW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_WK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sp_exp[3];
    logic [11:0] act, exp;
    vec_t v;
    sp_exp = '{6, 5, 5};
    n_vec = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; key_pressed = 1'b0; judge_valid = 1'b0; judge_correct = 1'b0;
    f_lv = 2'd0; f_sc = 2'd0;

    // Round 1: reset, start, press two cycles into WAIT_KEY, judged correct
    add(X_IDL, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    f_lv = 2'd3;
    add(X_NEW, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(X_WK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_WK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_WK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    correct_round(1);
    // Plain timeout, then key held into WAIT_KEY (never accepted)
    to_round(1'b0);
    add(X_WK, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    to_round(1'b1);
    add(X_WK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Press on the timeout cycle wins; judged wrong in first JUDGE cycle
    for (int i = 0; i < 7; i++) add(X_WK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_WR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(X_JG, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    f_lv = 2'd0;
    add(X_FBW, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(X_FBW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_GO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_GO, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // Restart from GAME_OVER, three timeouts back to GAME_OVER, restart again
    f_lv = 2'd3; f_sc = 2'd0;
    add(X_NEW, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(X_WK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      to_round(1'b0);
      if (f_lv != 2'd0) add(X_WK, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    add(X_GO, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    f_lv = 2'd3; f_sc = 2'd0;
    add(X_NEW, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(X_WK,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Score saturation; first round holds judge_req over 3 idle cycles
    correct_round(3);
    for (int r = 0; r < 4; r++) correct_round(0);
    // Reset in the middle of the judge handshake
    add(X_WR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(X_JG, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(X_JG, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    f_lv = 2'd0; f_sc = 2'd0;
    add(X_IDL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    add(X_IDL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    exp_instr = 3'd0; pend = 1'b0; pend_val = 3'd0;
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      rst = v.rst; start = v.start; key_pressed = v.key;
      judge_valid = v.jv; judge_correct = v.jc;
      step();
      if (pend) begin exp_instr = pend_val; pend = 1'b0; end
      if (v.st == X_NEW) begin pend_val = 3'(m_lfsr % 8'd6); pend = 1'b1; end
      if (v.rst) begin exp_instr = 3'd0; pend = 1'b0; end
      act = {judge_req, instr_valid, correct_flag, wrong_flag, game_over,
             lives, score, instruction};
      exp = {v.st == X_JG, (v.st == X_WK) || (v.st == X_WR) || (v.st == X_JG),
             v.st == X_FBC, v.st == X_FBW, v.st == X_GO, v.lv, v.sc, exp_instr};
      check("vec", i, act, exp);
    end

    // Response window and feedback length measured from a fresh start
    rst = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0); rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!wrong_flag && n < 40) begin drive(1'b0, 1'b0, 1'b0, 1'b0); n++; end
    check("timeout_len", 0, 12'(n), 12'd8);
    n = 0;
    while (wrong_flag && n < 40) begin n++; drive(1'b0, 1'b0, 1'b0, 1'b0); end
    check("wrong_len", 0, 12'(n), 12'd4);

`ifdef ROUND_SPEEDUP_EN
    // Window after 2, 4 and 6 correct answers
    rst = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0); rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
      n = 0;
      while (!wrong_flag && n < 40) begin drive(1'b0, 1'b0, 1'b0, 1'b0); n++; end
      check("window", r, 12'(n), 12'(sp_exp[r]));
      repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
